// File: rtl/instr_decode_stage.sv
// instr_decode_stage: FIFO-buffered instruction decode with registered field bundle.
// Optional DECODE_LINK_REG_EN: writenum forced to r7 for opcode 010 (link register).
module instr_decode_stage #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [15:0]                  in_instr,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0]                   opcode,
  output logic [1:0]                   ALUop,
  output logic [2:0]                   cond,
  output logic [1:0]                   shift,
  output logic [DATA_W-1:0]            sximm5,
  output logic [DATA_W-1:0]            sximm8,
  input  logic [1:0]                   nsel1,
  input  logic [1:0]                   nsel2,
  output logic [2:0]                   readnum1,
  output logic [2:0]                   writenum,
  output logic [2:0]                   readnum2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count;
  logic              r_valid;
  logic [2:0]        r_opcode, r_cond, r_rn, r_rd, r_rm;
  logic [1:0]        r_aluop, r_shift;
  logic [DATA_W-1:0] r_sximm5, r_sximm8;
  logic              w_full, w_push, w_pop;
  logic [15:0]       w_head;

  assign w_full = r_count == CW'(DEPTH);
  assign w_push = in_valid && !w_full;
  assign w_pop  = (r_count != '0) && (!r_valid || out_ready);
  assign w_head = r_mem[r_rp];

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= in_instr;

  // Pointers wrap for free since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_aluop  <= '0;
      r_cond   <= '0;
      r_shift  <= '0;
      r_rn     <= '0;
      r_rd     <= '0;
      r_rm     <= '0;
      r_sximm5 <= '0;
      r_sximm8 <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_valid  <= 1'b1;
        r_opcode <= w_head[15:13];
        r_aluop  <= w_head[12:11];
        r_cond   <= w_head[10:8];
        r_shift  <= (w_head[15:13] == 3'b100) ? 2'b00 : w_head[4:3];
        r_rn     <= w_head[10:8];
        r_rd     <= w_head[7:5];
        r_rm     <= w_head[2:0];
        r_sximm5 <= {{(DATA_W-5){w_head[4]}}, w_head[4:0]};
        r_sximm8 <= {{(DATA_W-8){w_head[7]}}, w_head[7:0]};
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = r_valid;
  assign count     = r_count;
  assign opcode    = r_opcode;
  assign ALUop     = r_aluop;
  assign cond      = r_cond;
  assign shift     = r_shift;
  assign sximm5    = r_sximm5;
  assign sximm8    = r_sximm8;
  assign readnum1  = nsel1 == 2'b00 ? r_rm : nsel1 == 2'b01 ? r_rd : nsel1 == 2'b10 ? r_rn : 3'd0;
  assign readnum2  = nsel2 == 2'b00 ? r_rm : nsel2 == 2'b01 ? r_rd : nsel2 == 2'b10 ? r_rn : 3'd0;
`ifdef DECODE_LINK_REG_EN
  assign writenum  = r_opcode == 3'b010 ? 3'd7 : readnum1;
`else
  assign writenum  = readnum1;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed table, corner sequences and random traffic vs a queue-based model.
module tb_instr_decode_stage;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instr = '0;
  logic [1:0] nsel1 = '0, nsel2 = '0;
  logic in_ready, out_valid;
  logic [2:0] opcode, cond, readnum1, writenum, readnum2;
  logic [1:0] ALUop, shift;
  logic [DATA_W-1:0] sximm5, sximm8;
  logic [CW-1:0] count;

  instr_decode_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .ALUop(ALUop), .cond(cond), .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
    .nsel1(nsel1), .nsel2(nsel2), .readnum1(readnum1), .writenum(writenum),
    .readnum2(readnum2), .count(count));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference: queue of raw words, plus the instruction currently presented.
  int mq[$];
  bit mv;
  int mi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mv = 0;
      mi = 0;
    end else if (flush) begin
      mq.delete();
      mv = 0;
    end else begin
      bit push, pop;
      push = in_valid && mq.size() < DEPTH;
      pop  = mq.size() > 0 && (!mv || out_ready);
      if (pop) begin
        mi = mq.pop_front();
        mv = 1;
      end else if (out_ready) mv = 0;
      if (push) mq.push_back(int'(in_instr));
    end
  end

  function automatic int f_op(int w);  return (w / 8192) % 8; endfunction
  function automatic int f_sel(int n, int w);
    return n == 0 ? w % 8 : n == 1 ? (w / 32) % 8 : n == 2 ? (w / 256) % 8 : 0;
  endfunction
  function automatic logic [DATA_W-1:0] f_sx(int w, int bits);
    int v;
    v = w % (1 << bits);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return DATA_W'(v);
  endfunction
  function automatic int f_wn(int n, int w);
`ifdef DECODE_LINK_REG_EN
    if (f_op(w) == 2) return 7;
`endif
    return f_sel(n, w);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    cmp("out_valid", 32'(out_valid), 32'(mv));
    cmp("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    cmp("count", 32'(count), 32'(mq.size()));
    cmp("opcode", 32'(opcode), 32'(f_op(mi)));
    cmp("ALUop", 32'(ALUop), 32'((mi / 2048) % 4));
    cmp("cond", 32'(cond), 32'((mi / 256) % 8));
    cmp("shift", 32'(shift), 32'(f_op(mi) == 4 ? 0 : (mi / 8) % 4));
    cmp("sximm5", 32'(sximm5), 32'(f_sx(mi, 5)));
    cmp("sximm8", 32'(sximm8), 32'(f_sx(mi, 8)));
    cmp("readnum1", 32'(readnum1), 32'(f_sel(nsel1, mi)));
    cmp("readnum2", 32'(readnum2), 32'(f_sel(nsel2, mi)));
    cmp("writenum", 32'(writenum), 32'(f_wn(nsel1, mi)));
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic rdy, input logic fl,
                      input logic [1:0] n1, input logic [1:0] n2);
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl; nsel1 = n1; nsel2 = n2;
    #1 check_all();
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  n1, n2;
    logic [2:0]  op, cnd, rn1, rn2, wn;
    logic [1:0]  alu, sh;
    logic [15:0] s5, s8;
  } vec_t;
  vec_t tbl[5];

  logic [15:0] pk[DEPTH+1];

  initial begin
    tbl[0] = '{16'hA0E5, 2'b10, 2'b01, 3'd5, 3'd0, 3'd0, 3'd7, 3'd0, 2'd0, 2'd0, 16'h0005, 16'hFFE5};
    tbl[1] = '{16'hD082, 2'b01, 2'b00, 3'd6, 3'd0, 3'd4, 3'd2, 3'd4, 2'd2, 2'd0, 16'h0002, 16'hFF82};
    tbl[2] = '{16'h8B5F, 2'b10, 2'b11, 3'd4, 3'd3, 3'd3, 3'd0, 3'd3, 2'd1, 2'd0, 16'hFFFF, 16'h005F};
    tbl[3] = '{16'hAB5F, 2'b00, 2'b01, 3'd5, 3'd3, 3'd7, 3'd2, 3'd7, 2'd1, 2'd3, 16'hFFFF, 16'h005F};
`ifdef DECODE_LINK_REG_EN
    tbl[4] = '{16'h4A7C, 2'b01, 2'b10, 3'd2, 3'd2, 3'd3, 3'd2, 3'd7, 2'd1, 2'd3, 16'hFFFC, 16'h007C};
`else
    tbl[4] = '{16'h4A7C, 2'b01, 2'b10, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 2'd1, 2'd3, 16'hFFFC, 16'h007C};
`endif
    #12;
    cmp("rst_count", 32'(count), 0);
    cmp("rst_out_valid", 32'(out_valid), 0);
    cmp("rst_in_ready", 32'(in_ready), 1);
    cmp("rst_sximm8", 32'(sximm8), 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].instr, 1'b1, 1'b0, tbl[i].n1, tbl[i].n2);
      step(1'b0, 16'h0, 1'b1, 1'b0, tbl[i].n1, tbl[i].n2);
      cmp("tbl_latency_valid", 32'(out_valid), 0);
      step(1'b0, 16'h0, 1'b1, 1'b0, tbl[i].n1, tbl[i].n2);
      cmp("tbl_out_valid", 32'(out_valid), 1);
      cmp("tbl_opcode", 32'(opcode), 32'(tbl[i].op));
      cmp("tbl_ALUop", 32'(ALUop), 32'(tbl[i].alu));
      cmp("tbl_cond", 32'(cond), 32'(tbl[i].cnd));
      cmp("tbl_shift", 32'(shift), 32'(tbl[i].sh));
      cmp("tbl_sximm5", 32'(sximm5), 32'(tbl[i].s5));
      cmp("tbl_sximm8", 32'(sximm8), 32'(tbl[i].s8));
      cmp("tbl_readnum1", 32'(readnum1), 32'(tbl[i].rn1));
      cmp("tbl_readnum2", 32'(readnum2), 32'(tbl[i].rn2));
      cmp("tbl_writenum", 32'(writenum), 32'(tbl[i].wn));
    end

    // Back-pressure: fill to DEPTH with the head held, then drain in order.
    for (int k = 0; k <= DEPTH; k++) pk[k] = 16'(16'h2000 * k + 16'h0011 * (k + 1) + 16'h0080 * (k % 2));
    step(1'b0, 16'h0, 1'b0, 1'b1, 2'b00, 2'b01);
    for (int k = 0; k <= DEPTH; k++) step(1'b1, pk[k], 1'b0, 1'b0, 2'b00, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'hFFFF, 1'b0, 1'b0, 2'b00, 2'b01);
      cmp("full_count", 32'(count), DEPTH);
      cmp("full_in_ready", 32'(in_ready), 0);
      cmp("held_sximm8", 32'(sximm8), 32'(f_sx(pk[0], 8)));
    end
    for (int k = 0; k <= DEPTH; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00, 2'b01);
      cmp("drain_valid", 32'(out_valid), 1);
      cmp("drain_order", 32'(sximm8), 32'(f_sx(pk[k], 8)));
    end

    // Full FIFO with push offered and pop taken, then push+pop together, then flush.
    for (int k = 0; k <= DEPTH; k++) step(1'b1, pk[k], 1'b0, 1'b0, 2'b10, 2'b00);
    step(1'b1, 16'h1234, 1'b1, 1'b0, 2'b10, 2'b00);
    cmp("full_pop_count", 32'(count), DEPTH);
    step(1'b1, 16'h5678, 1'b1, 1'b0, 2'b10, 2'b00);
    cmp("pop_only_count", 32'(count), DEPTH - 1);
    step(1'b1, 16'h9ABC, 0, 1'b1, 2'b10, 2'b00);
    cmp("pushpop_count", 32'(count), DEPTH - 1);
    step(1'b1, 16'hDEF0, 1'b0, 1'b0, 2'b10, 2'b00);
    cmp("flush_count", 32'(count), 0);
    cmp("flush_out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_count", 32'(count), 0);
        cmp("async_rst_valid", 32'(out_valid), 0);
        cmp("async_rst_sximm5", 32'(sximm5), 0);
        @(negedge clk) rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 40) == 0), 2'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
